if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Sequences the IF stage of the 5-stage pipeline: owns the PC, drives the instruction-memory
//  req/ack handshake and writes or clears the IF/ID register. Combines the ID-stage flush/redirect
//  (taken branch, j, jal, jr) with the ID load-use stall. Discards fetches made stale by a redirect
//  and buffers a fetch returned while ID is stalled. Counts inserted bubbles.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  CNT_W      16             width of saturating bubble counter
// PORTS
//  clock          in   1   single clock, all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  stall          in   1   ID load-use stall; IF/ID must hold
//  flush          in   1   ID redirect: current IF/ID content and in-flight fetch are wrong-path
//  redirect_pc    in   32  target PC, valid when flush=1
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address = pc; stable while imem_req=1
//  imem_ack       in   1   read data valid this cycle (>=1 cycle after req)
//  imem_rdata     in   32  instruction word
//  ifid_we        out  1   load IF/ID with ifid_inst/ifid_pc4
//  ifid_clr       out  1   load IF/ID with NOP (32'h0) bubble
//  ifid_inst      out  32  instruction to IF/ID
//  ifid_pc4       out  32  fetched PC + 4 to IF/ID
//  bubble_cnt     out  CNT_W  bubbles inserted since reset, saturates at all-ones
// BEHAVIOUR
//  Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
//  On reset: pc=RESET_PC, state=FETCH, hold buffer empty, bubble_cnt=0.
//   imem_req, ifid_we and ifid_clr are 0 in the reset cycle.
//  States:
//   FETCH  imem_req=1, imem_addr=pc.
//   DRAIN  imem_req=1, imem_addr=old pc; waits for the stale ack and drops its data.
//   HOLD   imem_req=0; buffered word waits for stall release.
//  FETCH, ack, no stall, no flush:
//   ifid_we=1, ifid_inst=imem_rdata, ifid_pc4=pc+4; pc<=pc+4; stay in FETCH.
//   Back-to-back acks give 1 instruction/cycle.
//  FETCH, ack, stall=1: capture {rdata, pc+4} in the hold buffer; pc<=pc+4; go to HOLD.
//   ifid_we=0 and ifid_clr=0, so IF/ID holds.
//  HOLD, stall=0: ifid_we=1 from the buffer; go to FETCH. The new request starts next cycle.
//  FETCH, no ack, stall=0: ifid_clr=1 (bubble); bubble_cnt++.
//  Flush has priority over stall, ack and the hold buffer:
//   ifid_clr=1, ifid_we=0, pc<=redirect_pc, hold buffer cleared, bubble_cnt++.
//   FETCH without ack -> DRAIN, which keeps the old address until ack, then goes to FETCH.
//   FETCH with ack, or HOLD -> FETCH. Data returned this cycle is dropped.
//   DRAIN + flush: pc<=new redirect_pc and stay in DRAIN (latest redirect wins).
//  ifid_we and ifid_clr are never both 1.
//  In DRAIN and in HOLD with stall=0 (buffer forwarded), no bubble is counted except on flush.
//  PC arithmetic is modulo 2^32; pc+4 wraps from 32'hFFFF_FFFC to 0. No alignment check.
//  Reset mid-fetch abandons the outstanding request.
//   The memory must not deliver an ack for a request issued before reset.
// STRUCTURE
//  Shared package if_pkg:
//   state enum {FETCH, DRAIN, HOLD}, NOP_INST=32'h0, RESET_PC default, PC_STEP=4.
//  One sub-module, if_hold_buf: one-entry {inst, pc4} buffer with load, drop and valid.
//  Everything else (FSM, PC register, counter) stays in this module.
// TESTING
//  1. reset, then ack every cycle -> imem_addr 0,4,8,12; ifid_we each cycle; ifid_pc4 4,8,12,16.
//  2. ack 2 cycles after req, no stall -> one ifid_clr per wait cycle; bubble_cnt=1 per instr.
//  3. stall=1 as ack returns 32'h8C22_0004 at pc 0x10 -> HOLD, IF/ID held.
//     Release after 3 cycles -> ifid_we, inst 8C22_0004, pc4 0x14; next addr 0x14.
//  4. flush, redirect_pc=0x400 while req to 0x20 lacks ack -> ifid_clr, DRAIN.
//     Addr stays 0x20 until ack; data dropped; next addr 0x400.
//  5. flush and stall together while in HOLD -> buffer dropped, ifid_clr=1, pc=0x400, no ifid_we.
//  6. pc=32'hFFFF_FFFC ack -> pc4 0; CNT_W=2 with 5 bubbles -> bubble_cnt saturates at 3.
//     Mid-DRAIN reset -> pc=RESET_PC, counter 0.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch controller
package if_pkg;
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_e;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/if_fetch_ctrl_hold_buf.sv
// if_hold_buf: one-entry {inst, pc4} buffer for a fetch returned while ID is stalled
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drop,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d, pc4_q, pc4_d;
  // drop wins over load so a flush always empties the entry
  always_comb begin
    valid_d = drop ? 1'b0 : (load | valid_q);
    inst_d  = load ? inst_i : inst_q;
    pc4_d   = load ? pc4_i : pc4_q;
  end
  // entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end
  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc4   = pc4_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage sequencer owning the PC, imem handshake and IF/ID write/clear
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_we,
  output logic             ifid_clr,
  output logic [31:0]      ifid_inst,
  output logic [31:0]      ifid_pc4,
  output logic [CNT_W-1:0] bubble_cnt
);
  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d, drain_pc_q, drain_pc_d, pc4;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hb_load, hb_drop, hb_valid, bump;
  logic [31:0]        hb_inst, hb_pc4;
  assign pc4        = pc_q + PC_STEP;
  assign imem_addr  = (state_q == DRAIN) ? drain_pc_q : pc_q;
  assign bubble_cnt = cnt_q;
  if_hold_buf u_hold (
    .clk    (clock),
    .rst    (reset),
    .load   (hb_load),
    .drop   (hb_drop),
    .inst_i (imem_rdata),
    .pc4_i  (pc4),
    .valid  (hb_valid),
    .inst   (hb_inst),
    .pc4    (hb_pc4)
  );
  // next state, PC and IF/ID control; flush outranks stall, ack and the buffer
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_pc_d = drain_pc_q;
    imem_req   = 1'b0;
    ifid_we    = 1'b0;
    ifid_clr   = 1'b0;
    ifid_inst  = imem_rdata;
    ifid_pc4   = pc4;
    hb_load    = 1'b0;
    hb_drop    = 1'b0;
    bump       = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (flush) begin
            ifid_clr   = 1'b1;
            bump       = 1'b1;
            hb_drop    = 1'b1;
            pc_d       = redirect_pc;
            drain_pc_d = pc_q;
            state_d    = imem_ack ? FETCH : DRAIN;
          end else if (imem_ack) begin
            pc_d    = pc4;
            ifid_we = !stall;
            hb_load = stall;
            state_d = stall ? HOLD : FETCH;
          end else if (!stall) begin
            ifid_clr = 1'b1;
            bump     = 1'b1;
          end
        end
        DRAIN: begin
          imem_req = 1'b1;
          if (flush) begin
            ifid_clr = 1'b1;
            bump     = 1'b1;
            pc_d     = redirect_pc;
          end
          if (imem_ack) state_d = FETCH;
        end
        HOLD: begin
          if (flush) begin
            ifid_clr = 1'b1;
            bump     = 1'b1;
            hb_drop  = 1'b1;
            pc_d     = redirect_pc;
            state_d  = FETCH;
          end else if (!stall) begin
            ifid_we   = hb_valid;
            ifid_inst = hb_inst;
            ifid_pc4  = hb_pc4;
            hb_drop   = 1'b1;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
    cnt_d = (bump && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // state, PC, drain address and bubble counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      drain_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_pc_q <= drain_pc_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed and randomized checks of if_fetch_ctrl against a behavioural model
module tb_if_fetch_ctrl;
  logic        clock = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, ifid_we, ifid_clr;
  logic [31:0] imem_addr, ifid_inst, ifid_pc4;
  logic [15:0] bubble_cnt;
  logic        s_req, s_we, s_clr;
  logic [31:0] s_addr, s_inst, s_pc4;
  logic [1:0]  s_cnt;
  int n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  if_fetch_ctrl u_dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_we(ifid_we), .ifid_clr(ifid_clr), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
    .bubble_cnt(bubble_cnt)
  );

  if_fetch_ctrl #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(s_req), .imem_addr(s_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_we(s_we), .ifid_clr(s_clr), .ifid_inst(s_inst), .ifid_pc4(s_pc4),
    .bubble_cnt(s_cnt)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic [31:0] rpc,
                       input logic ak, input logic [31:0] rd);
    stall = st; flush = fl; redirect_pc = rpc; imem_ack = ak; imem_rdata = rd;
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick;
    reset = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 1, 32'h1000 + i);
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick;
    n_tests++;
    if ({imem_req, ifid_we, ifid_clr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs got %b exp 000", {imem_req, ifid_we, ifid_clr});
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, bubble_cnt} !== {1'b1, 32'h0, 16'h0}) begin
      n_fail++; $display("FAIL reset_state got req=%b addr=%h cnt=%0d exp req=1 addr=0 cnt=0",
                         imem_req, imem_addr, bubble_cnt);
    end
  endtask

  task automatic test_stream;
    logic [97:0] got, exp;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 32'hA000_0000 + i);
      got = {imem_addr, ifid_we, ifid_clr, ifid_pc4, ifid_inst};
      exp = {32'(i * 4), 1'b1, 1'b0, 32'(i * 4 + 4), 32'hA000_0000 + 32'(i)};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL stream%0d got %h exp %h", i, got, exp); end
      tick;
    end
  endtask

  task automatic test_wait;
    apply_reset;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      n_tests++;
      if ({imem_req, ifid_we, ifid_clr, imem_addr} !== {3'b101, 32'(k * 4)}) begin
        n_fail++; $display("FAIL wait_bubble%0d got %b/%h exp 101/%h", k,
                           {imem_req, ifid_we, ifid_clr}, imem_addr, 32'(k * 4));
      end
      tick;
      drive(0, 0, 0, 1, 32'hB000_0000 + k);
      n_tests++;
      if ({ifid_we, ifid_clr, ifid_pc4} !== {2'b10, 32'(k * 4 + 4)}) begin
        n_fail++; $display("FAIL wait_ack%0d got %b/%h exp 10/%h", k, {ifid_we, ifid_clr},
                           ifid_pc4, 32'(k * 4 + 4));
      end
      tick;
      n_tests++;
      if (bubble_cnt !== 16'(k + 1)) begin
        n_fail++; $display("FAIL wait_cnt%0d got %0d exp %0d", k, bubble_cnt, k + 1);
      end
    end
  endtask

  task automatic test_hold;
    apply_reset;
    stream(4);
    drive(1, 0, 0, 1, 32'h8C22_0004);
    n_tests++;
    if ({imem_addr, ifid_we, ifid_clr} !== {32'h10, 2'b00}) begin
      n_fail++; $display("FAIL hold_capture got %h/%b exp 00000010/00", imem_addr, {ifid_we, ifid_clr});
    end
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      n_tests++;
      if ({imem_req, ifid_we, ifid_clr} !== 3'b000) begin
        n_fail++; $display("FAIL hold_wait%0d got %b exp 000", i, {imem_req, ifid_we, ifid_clr});
      end
      tick;
    end
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({ifid_we, ifid_clr, ifid_inst, ifid_pc4} !== {2'b10, 32'h8C22_0004, 32'h14}) begin
      n_fail++; $display("FAIL hold_release got %b/%h/%h exp 10/8c220004/00000014",
                         {ifid_we, ifid_clr}, ifid_inst, ifid_pc4);
    end
    tick;
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({imem_req, imem_addr, bubble_cnt} !== {1'b1, 32'h14, 16'h0}) begin
      n_fail++; $display("FAIL hold_next got %b/%h/%0d exp 1/00000014/0", imem_req, imem_addr, bubble_cnt);
    end
    tick;
  endtask

  task automatic test_flush_drain;
    apply_reset;
    stream(8);
    drive(0, 1, 32'h400, 0, 0);
    n_tests++;
    if ({imem_req, imem_addr, ifid_we, ifid_clr} !== {1'b1, 32'h20, 2'b01}) begin
      n_fail++; $display("FAIL flush_cycle got %b/%h/%b exp 1/00000020/01", imem_req, imem_addr, {ifid_we, ifid_clr});
    end
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0);
      n_tests++;
      if ({imem_req, imem_addr, ifid_we, ifid_clr} !== {1'b1, 32'h20, 2'b00}) begin
        n_fail++; $display("FAIL drain_wait%0d got %b/%h/%b exp 1/00000020/00", i, imem_req, imem_addr, {ifid_we, ifid_clr});
      end
      tick;
    end
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    n_tests++;
    if ({imem_addr, ifid_we, ifid_clr} !== {32'h20, 2'b00}) begin
      n_fail++; $display("FAIL drain_ack got %h/%b exp 00000020/00", imem_addr, {ifid_we, ifid_clr});
    end
    tick;
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({imem_req, imem_addr, bubble_cnt} !== {1'b1, 32'h400, 16'h1}) begin
      n_fail++; $display("FAIL drain_exit got %b/%h/%0d exp 1/00000400/1", imem_req, imem_addr, bubble_cnt);
    end
    tick;
  endtask

  task automatic test_flush_hold;
    apply_reset;
    stream(4);
    drive(1, 0, 0, 1, 32'h8C22_0004);
    tick;
    drive(1, 1, 32'h400, 0, 0);
    n_tests++;
    if ({imem_req, ifid_we, ifid_clr} !== 3'b001) begin
      n_fail++; $display("FAIL flush_hold got %b exp 001", {imem_req, ifid_we, ifid_clr});
    end
    tick;
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({imem_req, imem_addr, ifid_we, bubble_cnt} !== {1'b1, 32'h400, 1'b0, 16'h1}) begin
      n_fail++; $display("FAIL flush_hold_after got %b/%h/%b/%0d exp 1/00000400/0/1", imem_req, imem_addr, ifid_we, bubble_cnt);
    end
    tick;
    drive(0, 0, 0, 1, 32'h55);
    n_tests++;
    if ({ifid_we, ifid_inst, ifid_pc4} !== {1'b1, 32'h55, 32'h404}) begin
      n_fail++; $display("FAIL flush_hold_refetch got %b/%h/%h exp 1/00000055/00000404", ifid_we, ifid_inst, ifid_pc4);
    end
    tick;
  endtask

  task automatic test_wrap_sat;
    apply_reset;
    drive(0, 1, 32'hFFFF_FFFC, 1, 0);
    tick;
    drive(0, 0, 0, 1, 32'h1234_5678);
    n_tests++;
    if ({imem_addr, ifid_we, ifid_pc4} !== {32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_pc4 got %h/%b/%h exp fffffffc/1/00000000", imem_addr, ifid_we, ifid_pc4);
    end
    tick;
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    apply_reset;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      tick;
    end
    n_tests++;
    if ({s_cnt, bubble_cnt} !== {2'd3, 16'd5}) begin
      n_fail++; $display("FAIL sat_cnt got %0d/%0d exp 3/5", s_cnt, bubble_cnt);
    end
    drive(0, 0, 0, 1, 0);
    tick;
    drive(0, 1, 32'h400, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({imem_addr, bubble_cnt} !== {32'h4, 16'd6}) begin
      n_fail++; $display("FAIL drain_pre_reset got %h/%0d exp 00000004/6", imem_addr, bubble_cnt);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, bubble_cnt} !== {1'b1, 32'h0, 16'h0}) begin
      n_fail++; $display("FAIL drain_reset got %b/%h/%0d exp 1/00000000/0", imem_req, imem_addr, bubble_cnt);
    end
  endtask

  task automatic test_random;
    logic [31:0] pc = 32'h0, stale_addr = 32'h0, rpc, rd, e_inst, e_pc4;
    logic [63:0] held[$];
    logic        stale = 1'b0, prev_req = 1'b0, st, fl, ak, e_req, e_we, e_clr;
    int          cnt = 0, cnt0;
    logic [114:0] got, exp;
    apply_reset;
    for (int c = 0; c < 600; c++) begin
      st  = ($urandom % 4) == 0;
      fl  = ($urandom % 8) == 0;
      rpc = $urandom & 32'hFFFF_FFFC;
      rd  = $urandom;
      e_req = held.size() == 0;
      ak = e_req && prev_req && ($urandom % 2 == 0);
      if (stale && ak) fl = 1'b0;
      drive(st, fl, rpc, ak, rd);
      cnt0 = cnt;
      e_we = 1'b0; e_clr = 1'b0; e_inst = '0; e_pc4 = '0;
      got = {imem_req, ifid_we, ifid_clr, e_req ? imem_addr : 32'h0,
             e_we ? 64'h0 : 64'h0, bubble_cnt};
      exp = {e_req, 2'b00, e_req ? (stale ? stale_addr : pc) : 32'h0, 64'h0, 16'(cnt0)};
      if (fl) begin
        e_clr = 1'b1;
        if (!stale && held.size() == 0 && !ak) begin stale = 1'b1; stale_addr = pc; end
        held.delete();
        pc = rpc;
        cnt = (cnt < 65535) ? cnt + 1 : cnt;
      end else if (held.size() != 0) begin
        if (!st) begin e_we = 1'b1; {e_inst, e_pc4} = held.pop_front(); end
      end else if (stale) begin
        if (ak) stale = 1'b0;
      end else if (ak) begin
        if (st) held.push_back({rd, pc + 32'd4});
        else begin e_we = 1'b1; e_inst = rd; e_pc4 = pc + 32'd4; end
        pc = pc + 32'd4;
      end else if (!st) begin
        e_clr = 1'b1;
        cnt = (cnt < 65535) ? cnt + 1 : cnt;
      end
      got[113:112] = {ifid_we, ifid_clr};
      got[79:16]   = e_we ? {ifid_inst, ifid_pc4} : 64'h0;
      exp[113:112] = {e_we, e_clr};
      exp[79:16]   = {e_inst, e_pc4};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL random%0d got %h exp %h", c, got, exp); end
      prev_req = e_req;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_wait;
    test_hold;
    test_flush_drain;
    test_flush_hold;
    test_wrap_sat;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
